spu_issue_scoreboard: RTL and testbench

- Dual-issue hazard scoreboard for the SPU even/odd execution pipes.
- Tracks each in-flight instruction's destination register, write enable and latency through the 7-stage result pipeline, in lockstep with the stage registers.
- Each cycle it decides whether the even/odd candidates may issue (RAW, WAW and intra-bundle hazards).
- For every source operand it selects register file or a forwarding stage.

---
 rtl/spu_issue_scoreboard_if.sv | 45 ++++
 rtl/spu_issue_scoreboard.sv | 161 ++++++++++++++++
 tb/tb_spu_issue_scoreboard.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/spu_issue_scoreboard_if.sv
// Candidate/grant bundle between the SPU issue stage and its hazard scoreboard.
//   master : issue logic   - drives candidates and flush, receives grants/forward codes
//   slave  : scoreboard    - receives candidates and flush, drives grants/forward codes
// Signals (x = e for even pipe, o for odd pipe):
//   req_x, we_x, rt_x[RW], lat_x[LW]   candidate valid, writes RT, destination, latency
//   srcv_x[3], src_x[3*RW]             source valids {RC,RB,RA}, addresses RA at LSBs
//   flush                              kill all in-flight entries
//   grant_x                            candidate issues this cycle
//   fwd_x[12]                          per-source forward code, RA at LSBs
//   inflight[4]                        count of valid writing entries
interface spu_issue_scoreboard_if #(
   parameter int RW = 7,
   parameter int LW = 3
);
   logic            req_e;
   logic            req_o;
   logic            we_e;
   logic            we_o;
   logic [RW-1:0]   rt_e;
   logic [RW-1:0]   rt_o;
   logic [LW-1:0]   lat_e;
   logic [LW-1:0]   lat_o;
   logic [2:0]      srcv_e;
   logic [2:0]      srcv_o;
   logic [3*RW-1:0] src_e;
   logic [3*RW-1:0] src_o;
   logic            flush;
   logic            grant_e;
   logic            grant_o;
   logic [11:0]     fwd_e;
   logic [11:0]     fwd_o;
   logic [3:0]      inflight;

   modport master (
      output req_e, req_o, we_e, we_o, rt_e, rt_o, lat_e, lat_o,
             srcv_e, srcv_o, src_e, src_o, flush,
      input  grant_e, grant_o, fwd_e, fwd_o, inflight
   );

   modport slave (
      input  req_e, req_o, we_e, we_o, rt_e, rt_o, lat_e, lat_o,
             srcv_e, srcv_o, src_e, src_o, flush,
      output grant_e, grant_o, fwd_e, fwd_o, inflight
   );
endinterface

// File: rtl/spu_issue_scoreboard.sv
// Dual-issue hazard scoreboard for the SPU even/odd execution pipes.
// Each pipe keeps a DEPTH-deep shift register of {v, we, rt, lat} that moves in
// lockstep with the result pipeline; an entry leaving the last stage is its
// writeback. Every cycle the even/odd candidates are checked for RAW against
// in-flight results, for intra-bundle RAW/WAW, and each source operand gets a
// forward code: 0 = register file, else {pipe, stage}.
// Ports:
//   clk    clock
//   reset  synchronous, active-high
//   sb     slave side of spu_issue_scoreboard_if (candidates, flush, grants,
//          forward codes, inflight count)
module spu_issue_scoreboard #(
   parameter int DEPTH = 7,
   parameter int RW    = 7,
   parameter int LW    = 3
) (
   input  logic                   clk,
   input  logic                   reset,
   spu_issue_scoreboard_if.slave  sb
);

   // Depth of the pipe a candidate will enter. Both pipes are equal today, so
   // the in-flight WAW comparator never fires; it is kept for unequal pipes.
   localparam int CAND_DEPTH = DEPTH;

   logic [1:0][DEPTH-1:0]         v_q;
   logic [1:0][DEPTH-1:0]         we_q;
   logic [1:0][DEPTH-1:0][RW-1:0] rt_q;
   logic [1:0][DEPTH-1:0][LW-1:0] lat_q;

   logic [1:0]                    c_req;
   logic [1:0]                    c_we;
   logic [1:0][RW-1:0]            c_rt;
   logic [1:0][LW-1:0]            c_lat;
   logic [1:0][2:0]               c_srcv;
   logic [1:0][2:0][RW-1:0]       c_src;

   logic [1:0]                    raw_stall;
   logic [1:0]                    waw_stall;
   logic [1:0][11:0]              fwd_c;
   logic                          hit;
   logic                          rdy;
   logic [3:0]                    code;

   logic [2:0]                    intra_raw;
   logic                          block_o;
   logic                          grant_e_c;
   logic                          grant_o_c;
   logic [3:0]                    inflight_c;

   // Latency 0 is treated as 1 so a stored entry is always ready by stage 1.
   always_comb begin
      c_req  = {sb.req_o, sb.req_e};
      c_we   = {sb.we_o, sb.we_e};
      c_rt   = {sb.rt_o, sb.rt_e};
      c_lat  = {((sb.lat_o == '0) ? LW'(1) : sb.lat_o),
                ((sb.lat_e == '0) ? LW'(1) : sb.lat_e)};
      c_srcv = {sb.srcv_o, sb.srcv_e};
      for (int k = 0; k < 3; k++) begin
         c_src[0][k] = sb.src_e[k*RW +: RW];
         c_src[1][k] = sb.src_o[k*RW +: RW];
      end
   end

   // Source lookup: scan oldest to youngest and let later hits overwrite, so the
   // youngest match wins. Within a stage odd is scanned before even, giving even
   // priority at equal age.
   always_comb begin
      raw_stall = '0;
      waw_stall = '0;
      fwd_c     = '0;
      hit       = 1'b0;
      rdy       = 1'b0;
      code      = '0;
      for (int p = 0; p < 2; p++) begin
         for (int k = 0; k < 3; k++) begin
            hit  = 1'b0;
            rdy  = 1'b0;
            code = '0;
            for (int s = DEPTH; s >= 1; s--) begin
               for (int q = 1; q >= 0; q--) begin
                  if (v_q[q][s-1] && we_q[q][s-1] && (rt_q[q][s-1] == c_src[p][k])) begin
                     hit  = 1'b1;
                     rdy  = (s >= int'(lat_q[q][s-1]));
                     code = {1'(q), 3'(s)};
                  end
               end
            end
            if (c_srcv[p][k] && hit) begin
               if (rdy) fwd_c[p][k*4 +: 4] = code;
               else     raw_stall[p]       = 1'b1;
            end
         end
         // In-flight WAW: the older entry must not write back after the candidate.
         for (int s = 1; s <= DEPTH; s++) begin
            for (int q = 0; q < 2; q++) begin
               if (c_we[p] && v_q[q][s-1] && we_q[q][s-1] && (rt_q[q][s-1] == c_rt[p]) &&
                   ((DEPTH - s) > CAND_DEPTH)) begin
                  waw_stall[p] = 1'b1;
               end
            end
         end
      end
   end

   always_comb begin
      for (int k = 0; k < 3; k++) begin
         intra_raw[k] = sb.srcv_o[k] && (c_src[1][k] == sb.rt_e);
      end
      grant_e_c = c_req[0] & ~raw_stall[0] & ~waw_stall[0] & ~sb.flush & ~reset;
      block_o   = (sb.req_e & ~grant_e_c) |
                  (sb.req_e & sb.we_e & (|intra_raw)) |
                  (sb.req_e & sb.we_e & sb.we_o & (sb.rt_o == sb.rt_e));
      grant_o_c = c_req[1] & ~raw_stall[1] & ~waw_stall[1] & ~block_o & ~sb.flush & ~reset;
   end

   always_comb begin
      inflight_c = '0;
      for (int q = 0; q < 2; q++) begin
         for (int s = 0; s < DEPTH; s++) begin
            inflight_c = inflight_c + {3'b000, (v_q[q][s] & we_q[q][s])};
         end
      end
   end

   // Outputs are gated during reset because the state only clears on the edge.
   assign sb.grant_e  = grant_e_c;
   assign sb.grant_o  = grant_o_c;
   assign sb.fwd_e    = reset ? 12'h000 : fwd_c[0];
   assign sb.fwd_o    = reset ? 12'h000 : fwd_c[1];
   assign sb.inflight = reset ? 4'h0 : inflight_c;

   always_ff @(posedge clk) begin
      if (reset || sb.flush) begin
         v_q   <= '0;
         we_q  <= '0;
         rt_q  <= '0;
         lat_q <= '0;
      end else begin
         for (int s = DEPTH-1; s >= 1; s--) begin
            v_q[0][s]   <= v_q[0][s-1];
            we_q[0][s]  <= we_q[0][s-1];
            rt_q[0][s]  <= rt_q[0][s-1];
            lat_q[0][s] <= lat_q[0][s-1];
            v_q[1][s]   <= v_q[1][s-1];
            we_q[1][s]  <= we_q[1][s-1];
            rt_q[1][s]  <= rt_q[1][s-1];
            lat_q[1][s] <= lat_q[1][s-1];
         end
         v_q[0][0]   <= grant_e_c;
         we_q[0][0]  <= grant_e_c & c_we[0];
         rt_q[0][0]  <= grant_e_c ? c_rt[0] : '0;
         lat_q[0][0] <= grant_e_c ? c_lat[0] : '0;
         v_q[1][0]   <= grant_o_c;
         we_q[1][0]  <= grant_o_c & c_we[1];
         rt_q[1][0]  <= grant_o_c ? c_rt[1] : '0;
         lat_q[1][0] <= grant_o_c ? c_lat[1] : '0;
      end
   end

endmodule

// File: tb/tb_spu_issue_scoreboard.sv
module tb_spu_issue_scoreboard;

   logic clk;
   logic reset;
   int   n_cmp;
   int   n_bad;

   spu_issue_scoreboard_if #(.RW(7), .LW(3)) sb_if ();

   spu_issue_scoreboard #(.DEPTH(7), .RW(7), .LW(3)) dut (
      .clk   (clk),
      .reset (reset),
      .sb    (sb_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_e(input logic req, input logic we, input logic [6:0] rt, input logic [2:0] lat,
                        input logic [2:0] srcv, input logic [6:0] ra, input logic [6:0] rb,
                        input logic [6:0] rc);
      sb_if.req_e  = req;
      sb_if.we_e   = we;
      sb_if.rt_e   = rt;
      sb_if.lat_e  = lat;
      sb_if.srcv_e = srcv;
      sb_if.src_e  = {rc, rb, ra};
   endtask

   task automatic set_o(input logic req, input logic we, input logic [6:0] rt, input logic [2:0] lat,
                        input logic [2:0] srcv, input logic [6:0] ra, input logic [6:0] rb,
                        input logic [6:0] rc);
      sb_if.req_o  = req;
      sb_if.we_o   = we;
      sb_if.rt_o   = rt;
      sb_if.lat_o  = lat;
      sb_if.srcv_o = srcv;
      sb_if.src_o  = {rc, rb, ra};
   endtask

   task automatic idle();
      set_e(0, 0, 0, 0, 0, 0, 0, 0);
      set_o(0, 0, 0, 0, 0, 0, 0, 0);
      sb_if.flush = 1'b0;
   endtask

   task automatic drain();
      idle();
      for (int i = 0; i < 8; i++) step();
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      reset = 1'b1;
      idle();
      step();
      step();
      // Reset: outputs quiet even with a live candidate
      set_e(1, 1, 7'd1, 3'd1, 3'b001, 7'd1, 0, 0);
      #1;
      check("rst_grant_e", sb_if.grant_e, 0);
      check("rst_fwd_e", sb_if.fwd_e, 0);
      check("rst_inflight", sb_if.inflight, 0);
      idle();
      step();
      reset = 1'b0;
      #1;
      check("post_rst_inflight", sb_if.inflight, 0);

      // Independent pair
      set_e(1, 1, 7'd5, 3'd2, 0, 0, 0, 0);
      set_o(1, 1, 7'd9, 3'd4, 0, 0, 0, 0);
      #1;
      check("ind_grant_e", sb_if.grant_e, 1);
      check("ind_grant_o", sb_if.grant_o, 1);
      step();
      idle();
      #1;
      check("ind_inflight_c1", sb_if.inflight, 2);
      for (int i = 0; i < 6; i++) step();
      check("ind_inflight_c7", sb_if.inflight, 2);
      step();
      check("ind_inflight_c8", sb_if.inflight, 0);

      // RAW stall then forward from even stages 6 and 7
      set_e(1, 1, 7'd10, 3'd6, 0, 0, 0, 0);
      #1;
      check("raw_issue", sb_if.grant_e, 1);
      step();
      set_e(1, 0, 7'd11, 3'd1, 3'b001, 7'd10, 0, 0);
      for (int c = 1; c <= 5; c++) begin
         #1;
         check($sformatf("raw_stall_c%0d", c), sb_if.grant_e, 0);
         step();
      end
      #1;
      check("raw_grant_c6", sb_if.grant_e, 1);
      check("raw_fwd_c6", sb_if.fwd_e[3:0], 4'b0110);
      step();
      check("raw_fwd_c7", sb_if.fwd_e[3:0], 4'b0111);
      step();
      check("raw_fwd_c8", sb_if.fwd_e[3:0], 4'b0000);
      drain();

      // Intra-bundle RAW: odd RB reads even RT
      set_e(1, 1, 7'd3, 3'd3, 0, 0, 0, 0);
      set_o(1, 0, 7'd40, 3'd1, 3'b010, 7'd0, 7'd3, 7'd0);
      #1;
      check("intra_grant_e", sb_if.grant_e, 1);
      check("intra_grant_o", sb_if.grant_o, 0);
      step();
      set_e(0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      check("intra_stall_c1", sb_if.grant_o, 0);
      step();
      check("intra_stall_c2", sb_if.grant_o, 0);
      step();
      check("intra_grant_c3", sb_if.grant_o, 1);
      check("intra_fwd_rb", sb_if.fwd_o[7:4], 4'b0011);
      check("intra_fwd_ra", sb_if.fwd_o[3:0], 4'b0000);
      drain();

      // In-order block: odd waits for stalled even
      set_e(1, 1, 7'd30, 3'd3, 0, 0, 0, 0);
      #1;
      step();
      set_e(1, 0, 7'd31, 3'd1, 3'b001, 7'd30, 0, 0);
      set_o(1, 1, 7'd50, 3'd1, 0, 0, 0, 0);
      #1;
      check("ord_e_c1", sb_if.grant_e, 0);
      check("ord_o_c1", sb_if.grant_o, 0);
      step();
      check("ord_e_c2", sb_if.grant_e, 0);
      check("ord_o_c2", sb_if.grant_o, 0);
      step();
      check("ord_e_c3", sb_if.grant_e, 1);
      check("ord_o_c3", sb_if.grant_o, 1);
      check("ord_fwd_c3", sb_if.fwd_e[3:0], 4'b0011);
      drain();

      // Youngest match: even stage 4 vs odd stage 2, both ready
      set_e(1, 1, 7'd20, 3'd2, 0, 0, 0, 0);
      #1;
      step();
      idle();
      step();
      set_o(1, 1, 7'd20, 3'd2, 0, 0, 0, 0);
      #1;
      check("young_odd_issue", sb_if.grant_o, 1);
      step();
      idle();
      step();
      set_e(1, 0, 7'd60, 3'd1, 3'b001, 7'd20, 0, 0);
      #1;
      check("young_fwd", sb_if.fwd_e[3:0], 4'b1010);
      check("young_grant", sb_if.grant_e, 1);
      check("young_inflight", sb_if.inflight, 2);
      drain();

      // Flush with five writing entries in flight
      set_e(1, 1, 7'd1, 3'd1, 0, 0, 0, 0);
      set_o(1, 1, 7'd2, 3'd1, 0, 0, 0, 0);
      step();
      set_e(1, 1, 7'd3, 3'd1, 0, 0, 0, 0);
      set_o(1, 1, 7'd4, 3'd1, 0, 0, 0, 0);
      step();
      set_e(1, 1, 7'd5, 3'd1, 0, 0, 0, 0);
      set_o(0, 0, 0, 0, 0, 0, 0, 0);
      step();
      set_e(1, 0, 7'd70, 3'd1, 3'b001, 7'd5, 0, 0);
      set_o(1, 0, 7'd71, 3'd1, 3'b001, 7'd1, 0, 0);
      #1;
      check("fl_inflight_pre", sb_if.inflight, 5);
      check("fl_fwd_pre", sb_if.fwd_e[3:0], 4'b0001);
      sb_if.flush = 1'b1;
      #1;
      check("fl_grant_e", sb_if.grant_e, 0);
      check("fl_grant_o", sb_if.grant_o, 0);
      step();
      sb_if.flush = 1'b0;
      #1;
      check("fl_inflight_post", sb_if.inflight, 0);
      check("fl_fwd_e_post", sb_if.fwd_e, 0);
      check("fl_fwd_o_post", sb_if.fwd_o, 0);
      check("fl_grant_e_post", sb_if.grant_e, 1);
      drain();

      // Reset asserted mid-stall
      set_e(1, 1, 7'd12, 3'd7, 0, 0, 0, 0);
      set_o(1, 1, 7'd13, 3'd1, 0, 0, 0, 0);
      step();
      set_e(1, 0, 7'd14, 3'd1, 3'b001, 7'd12, 0, 0);
      set_o(0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      check("rs_stall", sb_if.grant_e, 0);
      check("rs_inflight_pre", sb_if.inflight, 2);
      reset = 1'b1;
      #1;
      check("rs_grant_in", sb_if.grant_e, 0);
      check("rs_inflight_in", sb_if.inflight, 0);
      step();
      reset = 1'b0;
      #1;
      check("rs_inflight_post", sb_if.inflight, 0);
      check("rs_fwd_post", sb_if.fwd_e, 0);
      check("rs_grant_post", sb_if.grant_e, 1);
      idle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
